// File: rtl/fp_mult_sched_pkg.sv
// rtl/fp_mult_sched_pkg.sv - shared types and IEEE-754 helpers for the multiplier scheduler
package fp_mult_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // True for +0 and -0 (magnitude bits all clear)
    function automatic logic is_zero(input logic [FP_W-1:0] x);
        return (x[30:0] == 31'd0);
    endfunction

    // True for infinities and NaNs (exponent all ones)
    function automatic logic is_inf_nan(input logic [FP_W-1:0] x);
        return (x[30:23] == 8'hFF);
    endfunction

endpackage

// File: rtl/fp_mult_sched_rr_arbiter.sv
// rtl/fp_mult_sched_rr_arbiter.sv - combinational round-robin one-hot grant from a start pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    // Scan from ptr upward with wrap; first asserted request wins
    always_comb begin : arb
        int  idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        grant    = '0;
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mult_sched.sv
// rtl/fp_mult_sched.sv - round-robin sharing of one FP multiplier with zero bypass and timeout
module fp_mult_sched
    import fp_mult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_data,
    output logic                   rsp_err,
    output logic                   m_x_rdy,
    output logic                   m_y_rdy,
    output logic [31:0]            m_x_data,
    output logic [31:0]            m_y_data,
    input  logic [31:0]            m_z_data,
    input  logic                   m_done,
    output logic [15:0]            skip_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_n;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_id;
    logic [FP_W-1:0]   sel_a, sel_b;
    logic              accept;
    logic              bypass;
    logic              timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign sel_a  = req_a[grant_id*FP_W +: FP_W];
    assign sel_b  = req_b[grant_id*FP_W +: FP_W];
    assign accept = (state == IDLE) && (|grant);
    // 0 x Inf and 0 x NaN must still see the multiplier so it can produce NaN
    assign bypass = (is_zero(sel_a) && !is_inf_nan(sel_b)) ||
                    (is_zero(sel_b) && !is_inf_nan(sel_a));
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // Grant is only offered in IDLE and is forced low while reset is held
    assign req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign rsp_valid = (state == RESP);
    assign m_x_rdy   = (state == BUSY);
    assign m_y_rdy   = (state == BUSY);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic: m_done takes priority over timeout in BUSY
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = bypass ? RESP : BUSY;
            BUSY: if (m_done || timeout_hit) state_n = RESP;
            RESP: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand/result capture, timeout counter, bypass statistics, pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            cnt      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            m_x_data <= '0;
            m_y_data <= '0;
            skip_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_id  <= grant_id;
                        rsp_err <= 1'b0;
                        if (bypass) begin
                            rsp_data <= {sel_a[31] ^ sel_b[31], 31'd0};
                            if (skip_cnt != 16'hFFFF) skip_cnt <= skip_cnt + 16'd1;
                        end else begin
                            m_x_data <= sel_a;
                            m_y_data <= sel_b;
                            cnt      <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (m_done) begin
                        rsp_data <= m_z_data;
                        rsp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data <= FP_QNAN;
                        rsp_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_sched.sv
// tb/tb_fp_mult_sched.sv - directed table-driven bench for fp_mult_sched
module tb_fp_mult_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 64;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a = '0;
    logic [NUM_REQ*32-1:0] req_b = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_err;
    logic                  m_x_rdy, m_y_rdy;
    logic [31:0]           m_x_data, m_y_data;
    logic [31:0]           m_z_data = '0;
    logic                  m_done = 1'b0;
    logic [15:0]           skip_cnt;

    int checks = 0;
    int errors = 0;

    // multiplier model controls / observations
    int          mul_lat = 0;
    logic        inject_done = 1'b0;
    logic [31:0] exp_x = '0, exp_y = '0;
    int          bcnt = 0;
    int          xrdy_cycles = 0;
    int          unstable = 0;
    int          bad_grant = 0;
    int          grants[$];

    fp_mult_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .m_x_rdy   (m_x_rdy),
        .m_y_rdy   (m_y_rdy),
        .m_x_data  (m_x_data),
        .m_y_data  (m_y_data),
        .m_z_data  (m_z_data),
        .m_done    (m_done),
        .skip_cnt  (skip_cnt)
    );

    always #5 clk = ~clk;

    // Multiplier model and grant monitor, evaluated mid-cycle
    always @(negedge clk) begin
        if (m_x_rdy) begin
            xrdy_cycles++;
            if (m_x_data !== exp_x || m_y_data !== exp_y || m_y_rdy !== 1'b1) unstable++;
            m_done = (mul_lat > 0) && (bcnt == mul_lat - 1);
            bcnt++;
        end else begin
            bcnt   = 0;
            m_done = inject_done;
        end
        if ((|req_ready) && (m_x_rdy || rsp_valid)) bad_grant++;
        if (|(req_ready & req_valid)) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i]) grants.push_back(i);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] z;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [15:0] exp_skip;
        int          exp_lat;
        int          exp_xrdy;
    } vec_t;

    task automatic run_op(input vec_t v);
        int n;
        exp_x    = v.a;
        exp_y    = v.b;
        mul_lat  = v.lat;
        m_z_data = v.z;
        rsp_ready = 1'b1;
        req_a[v.id*32 +: 32] = v.a;
        req_b[v.id*32 +: 32] = v.b;
        req_valid = NUM_REQ'(1) << v.id;
        #1;
        chk($sformatf("grant id%0d", v.id), 32'(req_ready), 32'(1) << v.id);
        xrdy_cycles = 0;
        step();
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 200) begin
            step();
            n++;
        end
        chk("latency", n, v.exp_lat);
        chk("rsp_id", 32'(rsp_id), v.id);
        chk("rsp_data", rsp_data, v.exp_data);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("skip_cnt", 32'(skip_cnt), 32'(v.exp_skip));
        chk("xrdy_cycles", xrdy_cycles, v.exp_xrdy);
        step();
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        int bad;
        logic [31:0] hold_data;

        vecs[0] = '{0, 32'h00000000, 32'h3F828F5C, 0, 32'h0, 32'h00000000, 1'b0, 16'd1, 1, 0};
        vecs[1] = '{0, 32'h40033333, 32'h80000000, 0, 32'h0, 32'h80000000, 1'b0, 16'd2, 1, 0};
        vecs[2] = '{2, 32'h40000000, 32'h40400000, 5, 32'h40C00000, 32'h40C00000, 1'b0, 16'd2, 6, 5};
        vecs[3] = '{1, 32'h00000000, 32'h7F800000, 3, 32'h7FC00000, 32'h7FC00000, 1'b0, 16'd2, 4, 3};
        vecs[4] = '{3, 32'h80000000, 32'h80000000, 0, 32'h0, 32'h00000000, 1'b0, 16'd3, 1, 0};
        vecs[5] = '{1, 32'h3F800000, 32'h80000000, 0, 32'h0, 32'h80000000, 1'b0, 16'd4, 1, 0};
        vecs[6] = '{3, 32'h7F800000, 32'h80000000, 2, 32'hFFC00000, 32'hFFC00000, 1'b0, 16'd4, 3, 2};
        vecs[7] = '{2, 32'h3F800000, 32'h3F800000, 0, 32'h0, 32'h7FC00000, 1'b1, 16'd4, TIMEOUT + 1, TIMEOUT};

        // reset state, including grant suppression while reset is held
        req_valid = 4'b0100;
        #1;
        chk("reset req_ready", 32'(req_ready), 32'h0);
        step();
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset m_x_rdy", 32'(m_x_rdy), 32'h0);
        chk("reset rsp_data", rsp_data, 32'h0);
        chk("reset skip_cnt", 32'(skip_cnt), 32'h0);
        chk("reset m_x_data", m_x_data, 32'h0);
        req_valid = '0;
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // late m_done while idle must not produce a response
        inject_done = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid !== 1'b0 || m_x_rdy !== 1'b0) bad++;
        end
        inject_done = 1'b0;
        step();
        chk("late done ignored", bad, 0);

        // back-pressure on the response: hold for 10 cycles, no new grant
        exp_x = 32'h40000000; exp_y = 32'h40000000; mul_lat = 3; m_z_data = 32'h40800000;
        req_a[31:0] = exp_x; req_b[31:0] = exp_y;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0010;
        n = 0;
        while (!rsp_valid && n < 50) begin
            step();
            n++;
        end
        chk("hold rsp_valid", 32'(rsp_valid), 32'h1);
        hold_data = rsp_data;
        chk("hold rsp_data", hold_data, 32'h40800000);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h40800000 || rsp_id !== 2'd0 ||
                rsp_err !== 1'b0 || req_ready !== 4'b0000) bad++;
        end
        chk("hold stable", bad, 0);
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        chk("hold released", 32'(rsp_valid), 32'h0);

        // reset during BUSY: multiplier handshake drops before any clock edge
        exp_x = 32'h3F800000; exp_y = 32'h40000000; mul_lat = 0;
        req_a[63:32] = exp_x; req_b[63:32] = exp_y;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        step();
        chk("busy m_x_rdy", 32'(m_x_rdy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async m_x_rdy", 32'(m_x_rdy), 32'h0);
        chk("async m_y_rdy", 32'(m_y_rdy), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("post rst rsp_data", rsp_data, 32'h0);
        chk("post rst skip_cnt", 32'(skip_cnt), 32'h0);
        chk("post rst m_y_data", m_y_data, 32'h0);

        // round-robin from pointer 0 with all requesters active
        exp_x = 32'h3F800000; exp_y = 32'h40000000; mul_lat = 2; m_z_data = 32'h40000000;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*32 +: 32] = exp_x;
            req_b[i*32 +: 32] = exp_y;
        end
        grants.delete();
        req_valid = 4'b1111;
        n = 0;
        while (grants.size() < 5 && n < 100) begin
            step();
            n++;
        end
        req_valid = '0;
        for (int i = 0; i < 8; i++) step();
        chk("rr grant count", grants.size(), 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr order %0d", k), (k < grants.size()) ? grants[k] : -1, k % NUM_REQ);

        chk("operands stable in busy", unstable, 0);
        chk("no grant outside idle", bad_grant, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_sched.md
Name: fp_mult_sched

Overview:
- Shares one single-precision floating-point multiplier (ports clk, x_rdy, y_rdy, x_data, y_data, z_data, done) among NUM_REQ requesters in the feedforward layer datapath.
- Arbitrates requests round-robin and sequences the multiplier handshake.
- Products with a ±0 operand bypass the multiplier and are answered in one cycle.
- Detects a multiplier that never asserts done (timeout) and returns a tagged error result.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of the requester index; must be at least clog2(NUM_REQ).
- TIMEOUT, 64, maximum BUSY cycles to wait for m_done before aborting.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_a  in  NUM_REQ*32  operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*32  operand B; slice i belongs to requester i.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  32  IEEE-754 product.
- rsp_err  out  1  result produced by timeout.
- m_x_rdy  out  1  to multiplier x_rdy.
- m_y_rdy  out  1  to multiplier y_rdy.
- m_x_data  out  32  to multiplier x_data.
- m_y_data  out  32  to multiplier y_data.
- m_z_data  in  32  from multiplier z_data.
- m_done  in  1  from multiplier done.
- skip_cnt  out  16  saturating count of zero-bypassed products.

Behaviour:
- Reset: asynchronous on rst_n low. All outputs go to 0, state IDLE, round-robin pointer 0, timeout counter 0, skip_cnt 0.
- Reset mid-operation: m_x_rdy and m_y_rdy drop immediately. Any in-flight result is discarded. m_done arriving after reset is ignored.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready is combinational, one-hot: the first requester with req_valid=1, searching from pointer upward with wrap.
  - On the clock edge where req_valid&req_ready, latch a, b and id.
  - Zero bypass applies when either operand has bits[30:0]==0 and the other operand's exponent != 8'hFF. Then rsp_data={a[31]^b[31],31'b0}, skip_cnt increments (saturating at 16'hFFFF), next state RESP.
  - 0×Inf and 0×NaN are not bypassed; they go to the multiplier.
  - Otherwise next state BUSY, timeout counter cleared.
  - m_done is ignored in IDLE.
- BUSY:
  - m_x_rdy=m_y_rdy=1; m_x_data/m_y_data hold the latched a/b, stable for the whole state.
  - req_ready=0.
  - When m_done=1, latch m_z_data into rsp_data, rsp_err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without m_done, set rsp_data=32'h7FC00000, rsp_err=1, go to RESP.
  - If m_done and timeout occur on the same cycle, m_done wins.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_err stable until rsp_ready=1.
  - m_x_rdy=m_y_rdy=0.
  - On rsp_valid&rsp_ready: pointer = (id+1) mod NUM_REQ, next state IDLE.
  - No new grant in the same cycle; at most one op is in flight.
- Outside BUSY, m_x_rdy and m_y_rdy are 0. m_x_data and m_y_data hold their last values.
- Latency from grant edge:
  - Bypass: rsp_valid on the next cycle.
  - Multiply: m_x_rdy rises on the next cycle; rsp_valid one cycle after the m_done cycle.
- Fairness: a continuously requesting input is granted within NUM_REQ operations.

Decomposition:
- Package fp_mult_pkg: FP_W=32, FP_QNAN=32'h7FC00000, state enum {IDLE,BUSY,RESP}, functions is_zero(x) (bits[30:0]==0) and is_inf_nan(x) (exponent==8'hFF).
- Sub-module rr_arbiter: parameterised NUM_REQ round-robin grant from a request vector plus pointer, purely combinational, one-hot output.

Test Plan:
1. Requester 0 sends a=32'h00000000, b=32'h3F828F5C -> no m_x_rdy pulse, next-cycle rsp_valid, rsp_id=0, rsp_data=32'h00000000, rsp_err=0, skip_cnt=1. Repeat with a=32'h40033333, b=32'h80000000 -> rsp_data=32'h80000000, skip_cnt=2.
2. Requester 2 sends 32'h40000000 × 32'h40400000; multiplier model asserts done after 5 cycles with 32'h40C00000 -> m_x_rdy=m_y_rdy=1 for exactly those cycles with stable operands; rsp_data=32'h40C00000, rsp_id=2.
3. All 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0. No grant while BUSY/RESP.
4. 32'h00000000 × 32'h7F800000 -> not bypassed, routed to multiplier, skip_cnt unchanged.
5. Multiplier model never asserts done -> after TIMEOUT=64 BUSY cycles, rsp_data=32'h7FC00000, rsp_err=1. A late m_done while in IDLE is ignored.
6. Hold rsp_ready=0 for 10 cycles in RESP -> outputs stable, no grant. Assert rst_n=0 during BUSY -> m_x_rdy falls asynchronously; after release, pointer=0 and all outputs 0.
